pipe_adder: RTL and testbench
=============================

PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits; legal range 2..64.
REQ-002 Parameter STAGES, default 2, number of carry chunks and pipeline stages after the input register; legal range 1..8, WIDTH divisible by STAGES.
REQ-003 Clock  input  1  single clock; all flops rising-edge.
REQ-004 Rst_n  input  1  asynchronous, active-low reset.
REQ-005 Cg_en  input  1  functional enable; low freezes all pipeline state.
REQ-006 In_valid  input  1  operand beat offered.
REQ-007 In_ready  output  1  block accepts the offered beat this cycle.
REQ-008 A, B  input  WIDTH each  operands.
REQ-009 Cin  input  1  carry-in (Sub=0) or borrow-in (Sub=1).
REQ-010 Sub  input  1  mode: 0 = add, 1 = subtract.
REQ-011 Out_valid  output  1  result beat present.
REQ-012 Out_ready  input  1  downstream accepts result.
REQ-013 Sum  output  WIDTH  result.
REQ-014 Carry  output  1  carry-out (add) or borrow-out (subtract).
REQ-015 Overflow  output  1  two's-complement signed overflow of the result.

Function
REQ-016 Add: {Carry,Sum} = A + B + Cin, full WIDTH+1-bit result.
REQ-017 Subtract: Sum = (A - B - Cin) mod 2^WIDTH, computed as A + ~B + !Cin; Carry = inverse of that adder's carry-out, i.e. 1 when A < B + Cin unsigned.
REQ-018 Overflow = 1 when the operand sign bits entering the adder, after B inversion, are equal and the Sum sign bit differs from them.
REQ-019 Stage 0 register captures A, B, Cin and Sub on each accepted beat; accepted means In_valid and In_ready both high at a rising edge.
REQ-020 Stage k (1..STAGES) adds bit chunk k-1 of width WIDTH/STAGES with the carry registered from stage k-1; lower result chunks and unconsumed operand chunks travel with the beat.
REQ-021 A beat accepted at edge E appears on Sum/Carry/Overflow with Out_valid=1 after edge E+STAGES, with no stall in between.
REQ-022 Global advance = Cg_en and (not Out_valid or Out_ready); In_ready equals advance and is combinational from Cg_en, Out_valid and Out_ready only.
REQ-023 When advance is low, every stage register, including its valid bit, holds its value.
REQ-024 When advance is high, each stage loads its predecessor; a stage with no valid predecessor becomes an invalid bubble, and bubbles are not compressed.
REQ-025 Full throughput: one beat per cycle while In_valid, Out_ready and Cg_en stay high.
REQ-026 Sum, Carry and Overflow are stable while Out_valid=1 and Out_ready=0.
REQ-027 While Out_valid=0, Sum, Carry and Overflow are don't-care but driven from registers, never combinational from inputs.
REQ-028 Cg_en low while In_valid is high: no beat is accepted and In_valid may persist until accepted.

Reset
REQ-029 Rst_n low asynchronously clears every stage valid bit, so Out_valid=0 and Sum=0, Carry=0, Overflow=0.
REQ-030 A reset asserted mid-operation discards all in-flight beats; none appears after reset release.
REQ-031 In_ready follows REQ-022 during reset; no beat is accepted while Rst_n is low.
REQ-032 The first beat can be accepted at the first rising edge after Rst_n deasserts.

Structure
REQ-033 Shared package pipe_adder_pkg holds the mode encoding (ADD=0, SUB=1) and the function computing the chunk width from WIDTH and STAGES.
REQ-034 One sub-module, adder_slice, is a registered chunk adder with a hold enable and a valid bit, instantiated STAGES times via generate.
REQ-035 The design uses no gated or muxed clocks; Cg_en is a synchronous enable only.

Verification (WIDTH=8, STAGES=2)
REQ-036 A=0x0F, B=0x01, Cin=0, Sub=0, accepted at edge E -> after edge E+2: Sum=0x10, Carry=0, Overflow=0, Out_valid=1.
REQ-037 A=0x7F, B=0x01, Cin=0, Sub=0 -> Sum=0x80, Carry=0, Overflow=1; A=0xFF, B=0x01, Cin=1 -> Sum=0x01, Carry=1, Overflow=0.
REQ-038 A=0x05, B=0x07, Cin=0, Sub=1 -> Sum=0xFE, Carry=1, Overflow=0; A=0x80, B=0x01, Sub=1 -> Sum=0x7F, Overflow=1.
REQ-039 Stream 10 beats with Out_ready low for cycles 3-6 -> In_ready drops and no beat is lost or duplicated; the output stays stable while stalled; results match a reference model in order.
REQ-040 Cg_en low for 4 cycles with 2 beats in flight -> state is frozen and In_ready=0; after Cg_en rises, both beats emerge in order with correct values.
REQ-041 Rst_n pulsed low asynchronously with 2 beats in flight -> Out_valid=0 and Sum=0 immediately; the discarded beats never appear, and a beat issued after release gives the correct result 2 cycles later.

Source files
------------

// File: rtl/pipe_adder_pkg.sv
// pipe_adder_pkg: shared definitions for the chunked pipelined adder.
//   MODE_ADD / MODE_SUB : encoding of the sub input
//   chunk_width()       : bits added per pipeline stage
package pipe_adder_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/pipe_adder_if.sv
// pipe_adder_if: operand/result handshake bundle for pipe_adder.
//   in_valid/in_ready       : operand beat handshake
//   a, b, cin, sub          : operands, carry/borrow-in, mode (0 add, 1 sub)
//   out_valid/out_ready     : result beat handshake
//   sum, carry, overflow    : result, carry/borrow-out, signed overflow
// master = beat producer / result consumer, slave = the adder.
interface pipe_adder_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             overflow;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, carry, overflow
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, carry, overflow
  );
endinterface

// File: rtl/adder_slice.sv
// adder_slice: one pipeline stage of pipe_adder. Adds operand chunk IDX
// (CW bits) with the incoming carry and registers the whole beat.
//   clk, rst_n            : clock, async active-low reset
//   adv                   : load enable; low holds every register
//   in_vld/out_vld        : beat valid bit
//   in_a/in_b             : operands (b already inverted for subtract)
//   in_c/out_c            : carry into / out of this chunk
//   in_sum/out_sum        : partial result, lower chunks already filled
//   in_sub/out_sub        : mode bit travelling with the beat
module adder_slice #(
  parameter int WIDTH = 8,
  parameter int CW    = 4,
  parameter int IDX   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_sum,
  input  logic             in_c,
  input  logic             in_sub,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_c,
  output logic             out_sub
);

  logic [CW:0]      chunk;
  logic [WIDTH-1:0] nxt_sum;

  always_comb begin
    chunk   = {1'b0, in_a[IDX*CW +: CW]} + {1'b0, in_b[IDX*CW +: CW]}
            + {{CW{1'b0}}, in_c};
    nxt_sum = in_sum;
    nxt_sum[IDX*CW +: CW] = chunk[CW-1:0];
  end

  // Data is cleared too so the final stage reads all-zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld <= 1'b0;
      out_a   <= '0;
      out_b   <= '0;
      out_sum <= '0;
      out_c   <= 1'b0;
      out_sub <= 1'b0;
    end else if (adv) begin
      out_vld <= in_vld;
      out_a   <= in_a;
      out_b   <= in_b;
      out_sum <= nxt_sum;
      out_c   <= chunk[CW];
      out_sub <= in_sub;
    end
  end

endmodule

// File: rtl/pipe_adder.sv
// pipe_adder: pipelined add/subtract, carry chain split into STAGES chunks.
//   clk, rst_n : clock, async active-low reset
//   cg_en      : synchronous enable; low freezes the whole pipeline
//   bus        : pipe_adder_if slave (operand and result handshakes)
// Latency: beat accepted at edge E is presented after edge E+STAGES.
// The pipeline moves as one unit (no bubble compression), so a stalled
// output holds every stage and back-pressures the input.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cg_en,
  pipe_adder_if.slave  bus
);

  localparam int CW = chunk_width(WIDTH, STAGES);

  if (WIDTH < 2 || WIDTH > 64 || STAGES < 1 || STAGES > 8 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipe_adder: unsupported WIDTH/STAGES combination");
  end

  logic                         adv;
  logic                         s0_vld, s0_cin, s0_sub;
  logic [WIDTH-1:0]             s0_a, s0_b;
  logic [STAGES:0]              vld_pipe, c_pipe, sub_pipe;
  logic [STAGES:0][WIDTH-1:0]   a_pipe, b_pipe, s_pipe;
  logic                         unused_bits;

  assign adv          = cg_en & (~vld_pipe[STAGES] | bus.out_ready);
  assign bus.in_ready = adv;

  // Stage 0: raw operand capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_vld <= 1'b0;
      s0_a   <= '0;
      s0_b   <= '0;
      s0_cin <= 1'b0;
      s0_sub <= 1'b0;
    end else if (adv) begin
      s0_vld <= bus.in_valid;
      s0_a   <= bus.a;
      s0_b   <= bus.b;
      s0_cin <= bus.cin;
      s0_sub <= bus.sub;
    end
  end

  // Subtract runs as a + ~b + !cin; the inverted b travels down the pipe
  // so the final overflow test sees the operand actually added.
  assign vld_pipe[0] = s0_vld;
  assign a_pipe[0]   = s0_a;
  assign b_pipe[0]   = (s0_sub == MODE_SUB) ? ~s0_b : s0_b;
  assign c_pipe[0]   = s0_cin ^ (s0_sub == MODE_SUB);
  assign sub_pipe[0] = s0_sub;
  assign s_pipe[0]   = '0;

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    adder_slice #(.WIDTH(WIDTH), .CW(CW), .IDX(k)) u_slice (
      .clk     (clk),
      .rst_n   (rst_n),
      .adv     (adv),
      .in_vld  (vld_pipe[k]),
      .in_a    (a_pipe[k]),
      .in_b    (b_pipe[k]),
      .in_sum  (s_pipe[k]),
      .in_c    (c_pipe[k]),
      .in_sub  (sub_pipe[k]),
      .out_vld (vld_pipe[k+1]),
      .out_a   (a_pipe[k+1]),
      .out_b   (b_pipe[k+1]),
      .out_sum (s_pipe[k+1]),
      .out_c   (c_pipe[k+1]),
      .out_sub (sub_pipe[k+1])
    );
  end

  // Outputs are decoded from final-stage registers only; those registers
  // reset to zero, which makes sum/carry/overflow all zero in reset.
  assign bus.out_valid = vld_pipe[STAGES];
  assign bus.sum       = s_pipe[STAGES];
  assign bus.carry     = c_pipe[STAGES] ^ sub_pipe[STAGES];
  assign bus.overflow  = (a_pipe[STAGES][WIDTH-1] == b_pipe[STAGES][WIDTH-1]) &
                         (s_pipe[STAGES][WIDTH-1] != a_pipe[STAGES][WIDTH-1]);

  // Only the sign bits of the operands matter once the last chunk is done.
  assign unused_bits = ^{a_pipe[STAGES][WIDTH-2:0], b_pipe[STAGES][WIDTH-2:0]};

endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: directed + randomized bench for pipe_adder (WIDTH=8,
// STAGES=2). Expected results come from signed/unsigned integer arithmetic
// on the operands, kept in an in-order queue.
module tb_pipe_adder;
  import pipe_adder_pkg::*;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  logic cg_en;
  always #5 clk = ~clk;

  pipe_adder_if #(.WIDTH(W)) bus();

  pipe_adder #(.WIDTH(W), .STAGES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cg_en (cg_en),
    .bus   (bus)
  );

  res_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  logic acc;
  logic last_rdy;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic res_t model(input logic [W-1:0] a, b, input logic cin, sub);
    int   ua, ub, sa, sb, ci, u, s;
    res_t r;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    ci = int'(cin);
    if (sub == MODE_ADD) begin
      u   = ua + ub + ci;
      s   = sa + sb + ci;
      r.c = (u > (1 << W) - 1);
    end else begin
      u   = ua - ub - ci;
      s   = sa - sb - ci;
      r.c = (u < 0);
    end
    r.s = u[W-1:0];
    r.v = (s > (1 << (W-1)) - 1) || (s < -(1 << (W-1)));
    return r;
  endfunction

  // Sampled mid-cycle, just before the next rising edge.
  task automatic monitor();
    res_t got;
    chk("in_ready_rule", 32'(bus.in_ready), 32'(cg_en & (~bus.out_valid | bus.out_ready)));
    last_rdy = bus.in_ready;
    if (bus.out_valid) begin
      chk("beat_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        got = {bus.sum, bus.carry, bus.overflow};
        chk("result", 32'(got), 32'(exp_q[0]));
        if (bus.out_ready && cg_en && rst_n) void'(exp_q.pop_front());
      end
    end
    acc = bus.in_valid && bus.in_ready && rst_n;
    if (acc) exp_q.push_back(model(bus.a, bus.b, bus.cin, bus.sub));
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [W-1:0] a, b, input logic cin, sub);
    bus.in_valid = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.cin = cin;
    bus.sub = sub;
  endtask

  task automatic drive_rand();
    drive(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
  endtask

  // One beat into an empty, free-running pipe; checks exact latency.
  task automatic directed(input string tag, input logic [W-1:0] a, b, input logic cin, sub,
                          input logic [W-1:0] es, input logic ec, ev);
    drive(a, b, cin, sub);
    tick();
    bus.in_valid = 1'b0;
    chk({tag, "_ov_e0"}, 32'(bus.out_valid), 32'd0);
    tick();
    chk({tag, "_ov_e1"}, 32'(bus.out_valid), 32'd0);
    tick();
    chk({tag, "_ov_e2"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_sum"},   32'(bus.sum),       32'(es));
    chk({tag, "_carry"}, 32'(bus.carry),     32'(ec));
    chk({tag, "_ovf"},   32'(bus.overflow),  32'(ev));
  endtask

  task automatic drain(input string tag);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    cg_en = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
    chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    res_t e;
    int   sent;
    logic saw_low;

    rst_n = 1'b0;
    cg_en = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 1'b0;
    bus.sub = 1'b0;
    #2;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_sum",       32'(bus.sum),       32'd0);
    chk("rst_carry",     32'(bus.carry),     32'd0);
    chk("rst_ovf",       32'(bus.overflow),  32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Fixed vectors; first one goes in at the first edge after release.
    directed("add_0f01", 8'h0F, 8'h01, 1'b0, MODE_ADD, 8'h10, 1'b0, 1'b0);
    directed("add_7f01", 8'h7F, 8'h01, 1'b0, MODE_ADD, 8'h80, 1'b0, 1'b1);
    directed("add_ff01", 8'hFF, 8'h01, 1'b1, MODE_ADD, 8'h01, 1'b1, 1'b0);
    directed("sub_0507", 8'h05, 8'h07, 1'b0, MODE_SUB, 8'hFE, 1'b1, 1'b0);
    directed("sub_8001", 8'h80, 8'h01, 1'b0, MODE_SUB, 8'h7F, 1'b0, 1'b1);
    directed("sub_0000b", 8'h00, 8'h00, 1'b1, MODE_SUB, 8'hFF, 1'b1, 1'b0);
    tick();

    // 10-beat stream with the sink stalled on cycles 3..6.
    sent = 0;
    saw_low = 1'b0;
    drive_rand();
    for (int c = 0; c < 60 && sent < 10; c++) begin
      bus.out_ready = !(c >= 3 && c <= 6);
      tick();
      if (c >= 3 && c <= 6 && !last_rdy) saw_low = 1'b1;
      if (acc) begin
        sent++;
        drive_rand();
      end
    end
    chk("stream_sent", 32'(sent), 32'd10);
    chk("stream_backpressure", 32'(saw_low), 32'd1);
    drain("stream");

    // Enable frozen for 4 cycles with two beats in flight.
    drive_rand();
    tick();
    drive_rand();
    tick();
    cg_en = 1'b0;
    drive_rand();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("freeze_in_ready", 32'(bus.in_ready), 32'd0);
      chk("freeze_out_valid", 32'(bus.out_valid), 32'd0);
    end
    cg_en = 1'b1;
    tick();
    chk("unfreeze_accept", 32'(acc), 32'd1);
    drain("freeze");

    // Random mix of valid, ready and enable.
    for (int i = 0; i < 120; i++) begin
      bus.in_valid  = ($urandom_range(3) != 0);
      bus.out_ready = ($urandom_range(2) != 0);
      cg_en         = ($urandom_range(4) != 0);
      if (acc || i == 0) begin
        bus.a = W'($urandom);
        bus.b = W'($urandom);
        bus.cin = 1'($urandom);
        bus.sub = 1'($urandom);
      end
      tick();
    end
    drain("random");

    // Async reset with two beats in flight; they must be discarded.
    drive_rand();
    tick();
    drive_rand();
    tick();
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_sum",       32'(bus.sum),       32'd0);
    exp_q.delete();
    drive_rand();
    tick();
    chk("rst_no_accept", 32'(acc), 32'd0);
    tick();
    rst_n = 1'b1;
    e = model(8'hA5, 8'h3C, 1'b1, MODE_SUB);
    directed("post_rst", 8'hA5, 8'h3C, 1'b1, MODE_SUB, e.s, e.c, e.v);
    for (int i = 0; i < 4; i++) tick();
    chk("post_rst_idle", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
